// File: rtl/branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// branch_resolve_bht
//
// Branch resolution unit for the EX stage with a direct-mapped branch history
// table (BHT) of 2-bit saturating counters.
//
// EX side:
// - Evaluates the RV32/RV64 B-type condition.
// - Compares the outcome against the prediction carried down from fetch.
// - One cycle later, presents a registered resolve/mispredict/redirect to
//   fetch.
// - Trains the BHT entry on the same clock edge.
//
// Fetch side:
// - Reads the same table combinationally for its next prediction.
// - There is no bypass: a lookup that hits the entry being trained in the
//   same cycle sees the old counter value.
//
// Optional feature (macro BRANCH_STATS_EN):
// - Adds stats_clr, stat_branches and stat_mispred.
// - The two counters are 32-bit and saturating.
// - They count resolves and mispredicting resolves.
//
// Parameters:
//   XLEN         operand / PC width (32 or 64)
//   BHT_ENTRIES  table depth, power of two, >= 2
//   CNT_RST      counter value after reset (weakly not-taken)
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   if_pc                 fetch PC used for the table lookup
//   if_pred_taken         prediction for if_pc (MSB of its counter)
//   ex_valid, ex_flush    EX slot valid / squashed by an older redirect
//   ex_is_b_type          EX instruction is a conditional branch
//   ex_funct3             branch condition select
//   ex_opr_a, ex_opr_b    rs1 / rs2 operand values
//   ex_pc, ex_target      branch PC and its taken target
//   ex_pred_taken         prediction made at fetch time for this branch
//   br_taken              combinational resolved outcome
//   res_valid             registered: a branch resolved last cycle
//   mispredict            registered: that branch was mispredicted
//   redirect_pc           registered: correct next PC for that branch
//   stats_clr             (BRANCH_STATS_EN) synchronous clear of statistics
//   stat_branches         (BRANCH_STATS_EN) resolved branch count
//   stat_mispred          (BRANCH_STATS_EN) mispredicted branch count
// ---------------------------------------------------------------------------
module branch_resolve_bht #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CNT_RST     = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic            ex_is_b_type,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_opr_a,
    input  logic [XLEN-1:0] ex_opr_b,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            br_taken,
    output logic            res_valid,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    input  logic            stats_clr,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      bht_q [BHT_ENTRIES];
    logic [1:0]      bht_d [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic            cond_true;
    logic            legal_f3;
    logic            resolve;
    logic [1:0]      cur_cnt;
    logic [1:0]      next_cnt;
    logic            res_valid_q, res_valid_d;
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            unused_pc_bits;

    // Word-aligned PCs: the two low bits never select an entry.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    assign if_pred_taken = bht_q[if_idx][1];

    // Condition evaluation.
    // funct3 010/011 are not branch encodings: they never resolve, so they
    // neither redirect nor train the table.
    always_comb begin
        cond_true = 1'b0;
        legal_f3  = 1'b1;
        case (ex_funct3)
            3'b000:  cond_true = (ex_opr_a == ex_opr_b);
            3'b001:  cond_true = (ex_opr_a != ex_opr_b);
            3'b100:  cond_true = ($signed(ex_opr_a) <  $signed(ex_opr_b));
            3'b101:  cond_true = ($signed(ex_opr_a) >= $signed(ex_opr_b));
            3'b110:  cond_true = (ex_opr_a <  ex_opr_b);
            3'b111:  cond_true = (ex_opr_a >= ex_opr_b);
            default: legal_f3  = 1'b0;
        endcase
    end

    assign resolve  = ex_valid & ~ex_flush & ex_is_b_type & legal_f3;
    assign br_taken = resolve & cond_true;

    // Next state for the result registers.
    // redirect_pc keeps its last value when nothing resolves.
    // The fall-through PC wraps naturally at the top of the address space.
    always_comb begin
        res_valid_d   = resolve;
        mispredict_d  = resolve & (br_taken != ex_pred_taken);
        redirect_pc_d = redirect_pc_q;
        if (resolve) begin
            redirect_pc_d = br_taken ? ex_target : (ex_pc + XLEN'(4));
        end
    end

    // Saturating counter training for the entry addressed by the EX branch.
    always_comb begin
        cur_cnt  = bht_q[ex_idx];
        next_cnt = cur_cnt;
        if (br_taken) begin
            if (cur_cnt != 2'b11) next_cnt = cur_cnt + 2'd1;
        end else begin
            if (cur_cnt != 2'b00) next_cnt = cur_cnt - 2'd1;
        end
        bht_d = bht_q;
        if (resolve) begin
            bht_d[ex_idx] = next_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_RST;
            end
        end else begin
            res_valid_q   <= res_valid_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    assign res_valid   = res_valid_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    // Clear takes priority over a same-cycle increment.
    // Both counters stick at all-ones.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (stats_clr) begin
            stat_branches_d = '0;
            stat_mispred_d  = '0;
        end else begin
            if (resolve && stat_branches_q != 32'hFFFF_FFFF)
                stat_branches_d = stat_branches_q + 32'd1;
            if (mispredict_d && stat_mispred_q != 32'hFFFF_FFFF)
                stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule
